// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding and default widths.
package pipe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;
endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used to count downstream stall cycles.
module pipe_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      r_cnt <= '0;
    else if (inc_i && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  assign cnt_o = r_cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// Skid-buffered pipeline stage register (main + skid entry); in_ready_o is purely registered.
// Optional stall counter enabled by macro PIPE_STAGE_PERF_EN.
import pipe_pkg::*;

module pipe_stage_reg #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o
`endif
);
  state_e            r_state, w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data, r_skid_data;
  logic              w_accept, w_drain;
  logic              w_load_main_in, w_load_main_skid, w_load_skid;

  assign in_ready_o  = (r_state != ST_FULL);
  assign out_valid_o = (r_state != ST_EMPTY);
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_drain     = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: if (w_accept) begin
        w_load_main_in = 1'b1;
        w_state_nxt    = ST_ONE;
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: if (w_drain) begin
        w_load_main_skid = 1'b1;
        w_state_nxt      = ST_ONE;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any simultaneous accept or drain; payload regs may go stale.
    if (flush_i) w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main_ctrl <= in_ctrl_i;
        r_main_data <= in_data_i;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= in_ctrl_i;
        r_skid_data <= in_data_i;
      end
    end
  end

  // Bubbles must never carry live control bits downstream.
  assign out_ctrl_o = out_valid_o ? r_main_ctrl : '0;
  assign out_data_o = r_main_data;

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (out_valid_o & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed streaming/backpressure/flush/reset plus random traffic.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 5;
`ifdef PIPE_STAGE_PERF_EN
  localparam int NW = 4;
`else
  localparam int NW = 16;
`endif

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [NW-1:0] stall_cnt;
  int            exp_cnt = 0;
`endif

  ent_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (out_ctrl),
    .out_data_o  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called just after a falling edge with inputs already set; checks, updates model, advances one cycle.
  task automatic step();
    ent_t e;
    logic acc, drn;
    chk("valid_model", out_valid, q.size() != 0);
    chk("ready_model", in_ready, q.size() < 2);
    if (!out_valid) chk("bubble_ctrl", out_ctrl, '0);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", stall_cnt, exp_cnt);
    if (out_valid && !out_ready && exp_cnt < 15) exp_cnt++;
`endif
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn && !flush) begin
      if (q.size() == 0) chk("sb_extra", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_data", out_data, e.d);
        chk("sb_ctrl", out_ctrl, e.c);
      end
    end
    if (flush) q.delete();
    else if (acc) q.push_back(ent_t'({in_ctrl, in_data}));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = d[CW-1:0] | 5'h1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Streaming at full throughput
    out_ready = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      in_valid = 1'b1; in_data = v; in_ctrl = 5'(v);
      chk("stream_in_ready", in_ready, 1);
      step();
      chk("stream_latency", out_data, v);
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Backpressure into FULL, then release
    out_ready = 1'b0;
    send(32'hA);
    send(32'hB);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out_data, 32'hA);
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();

    // Flush overrides a simultaneous accept while FULL
    out_ready = 1'b0;
    send(32'h11);
    send(32'h12);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hC; in_ctrl = 5'h1C;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (3) step();

    // Async reset between edges while holding one entry
    out_ready = 1'b0;
    send(32'h55);
    chk("pre_rst_data", out_data, 32'h55);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete();
`ifdef PIPE_STAGE_PERF_EN
    exp_cnt = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    step();

`ifdef PIPE_STAGE_PERF_EN
    // Saturating stall counter survives flush
    out_ready = 1'b0;
    send(32'h77);
    repeat (20) step();
    chk("perf_sat", stall_cnt, 15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("perf_after_flush", stall_cnt, 15);
`endif

    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 2) != 0;
      out_ready = ($urandom_range(0, 3)) != 0;
      in_data   = $urandom;
      in_ctrl   = 5'($urandom);
      flush     = ($urandom % 40) == 0;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("final_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: payload data width (ALU result, branch target, and similar).
REQ-002 Parameter CTRL_W, default 5: control-bit width (RegWrite, MemtoReg, Branch, MemRead, MemWrite).
REQ-003 Parameter CNT_W, default 16: stall-counter width; used only with PIPE_STAGE_PERF_EN.
REQ-004 clk_i  input  1: single clock, all state on rising edge.
REQ-005 rst_i  input  1: asynchronous, active-high reset.
REQ-006 flush_i  input  1: synchronous kill of all held entries.
REQ-007 in_valid_i  input  1: upstream presents an entry.
REQ-008 in_ready_o  output  1: stage can accept an entry this cycle.
REQ-009 in_ctrl_i  input  CTRL_W: upstream control bits.
REQ-010 in_data_i  input  DATA_W: upstream payload.
REQ-011 out_valid_o  output  1: stage presents an entry downstream.
REQ-012 out_ready_i  input  1: downstream accepts the entry this cycle.
REQ-013 out_ctrl_o  output  CTRL_W: control bits, forced to 0 when out_valid_o=0 (bubble).
REQ-014 out_data_o  output  DATA_W: payload of the main entry.
REQ-015 stall_cnt_o  output  CNT_W: downstream-stall cycle count; present only with PIPE_STAGE_PERF_EN.

Function
REQ-016 Storage: one main entry and one skid entry, each holding {ctrl, data, valid}.
REQ-017 State machine: EMPTY (no valid entries), ONE (main valid), FULL (main and skid valid).
REQ-018 Handshake: accept = in_valid_i & in_ready_o; drain = out_valid_o & out_ready_i.
REQ-019 in_ready_o = (state != FULL); it is driven from registered state only, with no combinational path from out_ready_i.
REQ-020 out_valid_o = (state != EMPTY); out_ctrl_o and out_data_o come from the main entry.
REQ-021 EMPTY: accept loads main and moves to ONE; otherwise the stage stays EMPTY.
REQ-022 ONE, accept & drain: main loads the input; state stays ONE (full throughput, 1 entry/cycle).
REQ-023 ONE, accept & ~drain: skid loads the input; state moves to FULL.
REQ-024 ONE, ~accept & drain: state moves to EMPTY.
REQ-025 ONE, ~accept & ~drain: state holds.
REQ-026 FULL, drain: main loads skid; state moves to ONE.
REQ-027 FULL, ~drain: state and both entries hold.
REQ-028 Latency: an entry accepted in cycle N is presented on out_* in cycle N+1 when the stage was EMPTY or draining.
REQ-029 Ordering: entries leave strictly in acceptance order; no entry is dropped or duplicated except by flush.
REQ-030 flush_i=1 at a rising edge: next state is EMPTY and both valid bits clear, overriding any simultaneous accept or drain.
REQ-031 flush_i=1: data registers may keep stale values, but out_ctrl_o reads 0 from the next cycle.
REQ-032 Held payload is stable while out_valid_o=1 & out_ready_i=0.

Reset
REQ-033 rst_i=1 asynchronously forces state EMPTY, both valid bits 0, all ctrl/data registers 0, and stall_cnt_o 0.
REQ-034 During reset: in_ready_o=1, out_valid_o=0, out_ctrl_o=0, out_data_o=0.
REQ-035 Reset asserted mid-transfer discards all entries; operation resumes at the first rising edge after rst_i deasserts.

Configuration
REQ-036 Macro PIPE_STAGE_PERF_EN defined: stall_cnt_o exists and increments each cycle out_valid_o=1 & out_ready_i=0, saturating at 2^CNT_W-1.
REQ-037 The counter is cleared only by reset, not by flush_i.
REQ-038 Macro PIPE_STAGE_PERF_EN undefined: the port and the counter logic are absent; all other behaviour is identical.

Structure
REQ-039 Shared package pipe_pkg: state encoding (EMPTY, ONE, FULL) and default DATA_W, CTRL_W, CNT_W constants.
REQ-040 The saturating counter is the one natural sub-module, pipe_perf_cnt, instantiated only under PIPE_STAGE_PERF_EN.

Verification
REQ-041 Streaming: out_ready_i=1; send data 0x1,0x2,0x3 on consecutive cycles -> out_data_o shows 0x1,0x2,0x3 one cycle later each; in_ready_o stays 1.
REQ-042 Backpressure: out_ready_i=0; send 0xA then 0xB -> state FULL, in_ready_o=0, 0xA held on the output; release out_ready_i -> 0xA then 0xB, no loss.
REQ-043 Flush priority: state FULL with flush_i=1 and in_valid_i=1 (0xC) -> next cycle out_valid_o=0, out_ctrl_o=0, in_ready_o=1; 0xC is never emitted.
REQ-044 Async reset: assert rst_i between clock edges while ONE -> outputs zero immediately, before the next edge.
REQ-045 Perf counter (macro on, CNT_W=4): hold out_valid_o=1 with out_ready_i=0 for 20 cycles -> stall_cnt_o saturates at 15; a flush leaves it at 15.
